// File: rtl/ultrasonic_scan_cntr_if.sv
// Handshake bundle between the ultrasonic scan controller and its user logic.
// The controller connects through the slave modport; the sensor/user side uses master.
interface ultrasonic_scan_cntr_if #(
  parameter int CH     = 4,
  parameter int DIST_W = 9
);
  localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;

  logic                   enable;
  logic [CH-1:0]          echo;
  logic [CH-1:0]          trig;
  logic [CH*DIST_W-1:0]   distance_cm;
  logic [CH-1:0]          valid;
  logic [CH-1:0]          timeout;
  logic                   busy;
  logic [CH_W-1:0]        cur_ch;

  modport master (
    output enable, echo,
    input  trig, distance_cm, valid, timeout, busy, cur_ch
  );

  modport slave (
    input  enable, echo,
    output trig, distance_cm, valid, timeout, busy, cur_ch
  );
endinterface

// File: rtl/ultrasonic_scan_cntr.sv
// Round-robin HC-SR04 ranging controller: triggers one sensor per period and measures echo in cm.
// Define ULTRA_AVG_EN to publish the mean of the previous and the new valid result per channel.
module ultrasonic_scan_cntr #(
  parameter int SYS_FREQ   = 100_000_000,
  parameter int CH         = 4,
  parameter int DIST_W     = 9,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 25_000,
  parameter int PERIOD_US  = 60_000
) (
  input logic                  clk,
  input logic                  reset_p,
  ultrasonic_scan_cntr_if.slave bus
);
  localparam int DIV    = SYS_FREQ / 1_000_000;
  localparam int DIV_W  = $clog2(DIV);
  localparam int CH_W   = (CH > 1) ? $clog2(CH) : 1;
  localparam int ST_MAX = (TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US;
  localparam int ST_W   = $clog2(ST_MAX + 1);
  localparam int PER_W  = $clog2(PERIOD_US + 1);
  localparam logic [DIST_W-1:0] DIST_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_GAP
  } state_t;

  state_t state_reg, state_next;

  logic [DIV_W-1:0]      div_cnt_reg;
  logic                  us_tick;
  logic [ST_W-1:0]       st_cnt_reg;
  logic [PER_W-1:0]      per_cnt_reg;
  logic [5:0]            sub_cnt_reg;
  logic [DIST_W-1:0]     cm_cnt_reg;
  logic [DIST_W-1:0]     cm_meas;
  logic [DIST_W-1:0]     pub_value;
  logic [CH_W-1:0]       cur_ch_reg;

  logic [CH-1:0]         sync1_reg;
  logic [CH-1:0]         echo_s_reg;
  logic [CH-1:0]         echo_d_reg;
  logic                  echo_rise;
  logic                  echo_fall;

  logic [CH*DIST_W-1:0]  dist_reg;
  logic [CH-1:0]         valid_reg;
  logic [CH-1:0]         timeout_reg;
  logic [CH-1:0]         trig_vec;

  logic                  enter_trig;
  logic                  state_clr;
  logic                  take_result;
  logic                  take_timeout;
  logic                  ch_advance;
  logic                  st_run;

  // ---------------------------------------------------------------- timebase
  assign us_tick = (div_cnt_reg == DIV_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset_p || enter_trig || us_tick) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------- echo input
  always_ff @(posedge clk) begin
    if (reset_p) begin
      sync1_reg  <= '0;
      echo_s_reg <= '0;
      echo_d_reg <= '0;
    end else begin
      sync1_reg  <= bus.echo;
      echo_s_reg <= sync1_reg;
      echo_d_reg <= echo_s_reg;
    end
  end

  assign echo_rise = echo_s_reg[cur_ch_reg] & ~echo_d_reg[cur_ch_reg];
  assign echo_fall = ~echo_s_reg[cur_ch_reg] & echo_d_reg[cur_ch_reg];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    enter_trig   = 1'b0;
    state_clr    = 1'b0;
    take_result  = 1'b0;
    take_timeout = 1'b0;
    ch_advance   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (bus.enable) begin
          state_next = S_TRIG;
          enter_trig = 1'b1;
        end
      end
      S_TRIG: begin
        if (us_tick && (st_cnt_reg == ST_W'(TRIG_US - 1))) begin
          state_next = S_WAIT_RISE;
          state_clr  = 1'b1;
        end
      end
      S_WAIT_RISE: begin
        // A level already high on entry has no rising edge, so it is never accepted.
        if (echo_rise) begin
          state_next = S_MEASURE;
          state_clr  = 1'b1;
        end else if (us_tick && (st_cnt_reg == ST_W'(TIMEOUT_US - 1))) begin
          state_next   = S_GAP;
          take_timeout = 1'b1;
        end
      end
      S_MEASURE: begin
        if (echo_fall) begin
          state_next  = S_GAP;
          take_result = 1'b1;
        end else if (us_tick && (st_cnt_reg == ST_W'(TIMEOUT_US - 1))) begin
          state_next   = S_GAP;
          take_timeout = 1'b1;
        end
      end
      S_GAP: begin
        if (us_tick && (per_cnt_reg == PER_W'(PERIOD_US - 1))) begin
          ch_advance = 1'b1;
          if (bus.enable) begin
            state_next = S_TRIG;
            enter_trig = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- counters
  assign st_run = (state_reg == S_TRIG) || (state_reg == S_WAIT_RISE) ||
                  (state_reg == S_MEASURE);

  always_ff @(posedge clk) begin
    if (reset_p || enter_trig || state_clr) begin
      st_cnt_reg <= '0;
    end else if (us_tick && st_run) begin
      st_cnt_reg <= st_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p || enter_trig) begin
      per_cnt_reg <= '0;
    end else if (us_tick && (state_reg != S_IDLE)) begin
      per_cnt_reg <= per_cnt_reg + 1'b1;
    end
  end

  // The tick landing in the fall-detect cycle is folded in, so the window is exactly the pulse width.
  assign cm_meas = (us_tick && (sub_cnt_reg == 6'd57) && (cm_cnt_reg != DIST_MAX)) ?
                   cm_cnt_reg + 1'b1 : cm_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset_p || state_clr) begin
      sub_cnt_reg <= '0;
      cm_cnt_reg  <= '0;
    end else if (us_tick && (state_reg == S_MEASURE)) begin
      if (sub_cnt_reg == 6'd57) begin
        sub_cnt_reg <= '0;
        cm_cnt_reg  <= cm_meas;
      end else begin
        sub_cnt_reg <= sub_cnt_reg + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- averaging
`ifdef ULTRA_AVG_EN
  logic [DIST_W-1:0] prev_reg [CH];
  logic [CH-1:0]     prev_ok_reg;
  logic [DIST_W:0]   avg_sum;

  always_comb begin
    avg_sum   = {1'b0, prev_reg[cur_ch_reg]} + {1'b0, cm_meas};
    pub_value = prev_ok_reg[cur_ch_reg] ? avg_sum[DIST_W:1] : cm_meas;
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      prev_ok_reg <= '0;
      for (int k = 0; k < CH; k++) begin
        prev_reg[k] <= '0;
      end
    end else if (take_result) begin
      prev_reg[cur_ch_reg]    <= cm_meas;
      prev_ok_reg[cur_ch_reg] <= 1'b1;
    end else if (take_timeout) begin
      prev_ok_reg[cur_ch_reg] <= 1'b0;
    end
  end
`else
  assign pub_value = cm_meas;
`endif

  // ---------------------------------------------------------------- results
  always_ff @(posedge clk) begin
    if (reset_p) begin
      dist_reg    <= '0;
      valid_reg   <= '0;
      timeout_reg <= '0;
      cur_ch_reg  <= '0;
    end else begin
      valid_reg <= '0;
      if (take_result) begin
        dist_reg[cur_ch_reg*DIST_W +: DIST_W] <= pub_value;
        timeout_reg[cur_ch_reg]               <= 1'b0;
        valid_reg[cur_ch_reg]                 <= 1'b1;
      end else if (take_timeout) begin
        dist_reg[cur_ch_reg*DIST_W +: DIST_W] <= DIST_MAX;
        timeout_reg[cur_ch_reg]               <= 1'b1;
        valid_reg[cur_ch_reg]                 <= 1'b1;
      end
      if (ch_advance) begin
        cur_ch_reg <= (cur_ch_reg == CH_W'(CH - 1)) ? '0 : cur_ch_reg + 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_trig
      assign trig_vec[gi] = (state_reg == S_TRIG) && (cur_ch_reg == CH_W'(gi));
    end
  endgenerate

  assign bus.trig        = trig_vec;
  assign bus.distance_cm = dist_reg;
  assign bus.valid       = valid_reg;
  assign bus.timeout     = timeout_reg;
  assign bus.busy        = (state_reg != S_IDLE);
  assign bus.cur_ch      = cur_ch_reg;

endmodule
